const_mult_seq_16b_sqrt2: RTL

- Sequential inverse companion of the FFT twiddle multiplier by sqrt(2)/2: multiplies a signed 16-bit sample by sqrt(2), approximated as 5793/4096 (about 1.41431).
- Used where a previously halved-by-sqrt2 value must be restored, e.g. the inverse-FFT / normalisation path.
- Uses sign-magnitude processing and a shift-add of 6 power-of-two terms, one term per clock, behind valid/ready handshakes.

---
 rtl/const_mult_seq_16b_sqrt2.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/const_mult_seq_16b_sqrt2.sv
// const_mult_seq_16b_sqrt2
//   Sequential multiply of a signed 16-bit sample by sqrt(2) ~= 5793/4096.
//   Works on the magnitude with one shift-add term per clock, then restores
//   the sign with saturation. Handshakes on both sides use valid/ready.
//
// Build option: define CONST_MULT_SQRT2_ROUND_EN to round half-up on the
//   magnitude in FIN instead of truncating. Latency and handshake are the same.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_data is valid
//   in_ready   block can accept a sample (IDLE only)
//   in_data    signed two's-complement sample
//   out_valid  out_data is valid (DONE)
//   out_ready  downstream accepts out_data
//   out_data   signed two's-complement result, held after handshake
//   busy       high whenever the FSM is not in IDLE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a sample, in_ready high
// ACC   | adding mag << S[k] into acc, S = {12,10,9,7,5,0}
// FIN   | scale down by 4096, apply sign and saturation, register out
// DONE  | presenting out_data until out_ready

module const_mult_seq_16b_sqrt2 #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic                  sign_q;
  logic [16:0]           mag_q;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic [2:0]            k_q;
  logic [DATA_WIDTH-1:0] out_q;

  logic                  accept;
  logic [16:0]           in_ext;
  logic [16:0]           in_mag;
  logic [3:0]            shamt;
  logic [ACC_WIDTH-1:0]  term;
  logic [ACC_WIDTH-1:0]  acc_fin;
  logic [ACC_WIDTH-1:0]  q;
  logic [DATA_WIDTH-1:0] result;

  // in_ready is gated by rst_n so it stays low while reset is held.
  assign in_ready  = (state == IDLE) && rst_n;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = out_q;

  // 17-bit magnitude so that 0x8000 maps to 32768 without wrapping.
  assign in_ext = {in_data[DATA_WIDTH-1], in_data};
  assign in_mag = in_data[DATA_WIDTH-1] ? (~in_ext + 17'd1) : in_ext;

  always_comb begin
    shamt = 4'd0;
    case (k_q)
      3'd0:    shamt = 4'd12;
      3'd1:    shamt = 4'd10;
      3'd2:    shamt = 4'd9;
      3'd3:    shamt = 4'd7;
      3'd4:    shamt = 4'd5;
      default: shamt = 4'd0;
    endcase
  end

  assign term = ACC_WIDTH'(mag_q) << shamt;

`ifdef CONST_MULT_SQRT2_ROUND_EN
  assign acc_fin = acc_q + ACC_WIDTH'(2048);
`else
  assign acc_fin = acc_q;
`endif

  assign q = acc_fin >> 12;

  // Negative side may reach 32768 (0x8000); zero is never negated into
  // anything but zero since -0 == 0 in two's complement.
  always_comb begin
    result = '0;
    if (!sign_q) begin
      if (q > ACC_WIDTH'(32767)) result = DATA_WIDTH'(16'h7FFF);
      else                       result = q[DATA_WIDTH-1:0];
    end else begin
      if (q > ACC_WIDTH'(32768)) result = DATA_WIDTH'(16'h8000);
      else                       result = ~q[DATA_WIDTH-1:0] + DATA_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = ACC;
      ACC:  if (k_q == 3'd5) state_next = FIN;
      FIN:  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      mag_q  <= '0;
      acc_q  <= '0;
      k_q    <= '0;
      out_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign_q <= in_data[DATA_WIDTH-1];
            mag_q  <= in_mag;
            acc_q  <= '0;
            k_q    <= '0;
          end
        end
        ACC: begin
          acc_q <= acc_q + term;
          k_q   <= k_q + 3'd1;
        end
        FIN: out_q <= result;
        default: ;
      endcase
    end
  end

endmodule
